pipeline_hazard_unit: RTL

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

---
 rtl/pipeline_hazard_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_unit.sv
// Purpose : tracks EX/MEM/WB destination registers and resolves decode-stage
//           read-after-write hazards with forwarding selects or a load-use stall.
// Latency : combinational outputs from the three tracking registers and the decode inputs.
// Backpressure: stall holds PC and IF/ID for one cycle per load-use and injects an EX bubble.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   id_valid, id_rs,
//   id_rs_used, id_rd,
//   id_regwrite, id_load  - decode-stage instruction description
//   flush                 - taken branch; squashes the decode instruction
//   fwd_sel               - per read port: 00 regfile, 01 EX result, 10 MEM result
//   stall                 - load-use hazard on the decode instruction
//   ex/mem/wb_valid       - stage occupancy
//   stall_count           - saturating count of stall cycles
module pipeline_hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NUM_RD*ADDR_W-1:0] id_rs,
  input  logic [NUM_RD-1:0]        id_rs_used,
  input  logic [ADDR_W-1:0]        id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_load,
  input  logic                     flush,
  output logic [2*NUM_RD-1:0]      fwd_sel,
  output logic                     stall,
  output logic                     ex_valid,
  output logic                     mem_valid,
  output logic                     wb_valid,
  output logic [CNT_W-1:0]         stall_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              regwrite;
    logic              load;
  } entry_t;

  entry_t ex_q, mem_q, wb_q;
  entry_t id_entry;
  logic   load_use_hit;
  logic [2*NUM_RD-1:0] fwd_raw;

  // A write to the hardwired-zero register is architecturally a no-op, so it
  // never produces a value worth forwarding or waiting for.
  function automatic logic writing(input entry_t e);
    return e.valid && e.regwrite && (e.rd != ZERO_IDX);
  endfunction

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = 1'b1;
    id_entry.rd       = id_rd;
    id_entry.regwrite = id_regwrite;
    id_entry.load     = id_load;
  end

  always_comb begin
    logic [ADDR_W-1:0] rs_k;
    logic              live;
    load_use_hit = 1'b0;
    fwd_raw      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rs_k = id_rs[k*ADDR_W +: ADDR_W];
      live = id_rs_used[k] && (rs_k != ZERO_IDX);
      if (live && writing(ex_q) && (rs_k == ex_q.rd) && ex_q.load)
        load_use_hit = 1'b1;
      // A load in EX has no result yet, so it cannot be the EX forward source;
      // the youngest non-load EX writer shadows any older MEM writer.
      if (live && writing(ex_q) && (rs_k == ex_q.rd) && !ex_q.load)
        fwd_raw[2*k +: 2] = 2'b01;
      else if (live && writing(mem_q) && (rs_k == mem_q.rd))
        fwd_raw[2*k +: 2] = 2'b10;
    end
  end

  // Reset masks the outputs so nothing tracked before reset is visible while it is held.
  assign stall     = !reset && id_valid && !flush && load_use_hit;
  assign fwd_sel   = reset ? '0 : fwd_raw;
  assign ex_valid  = !reset && ex_q.valid;
  assign mem_valid = !reset && mem_q.valid;
  assign wb_valid  = !reset && wb_q.valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (id_valid && !stall && !flush) ? id_entry : '0;
      if (stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

  // WB only reports occupancy; its register file write happens elsewhere.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.rd, wb_q.regwrite, wb_q.load};

endmodule
